mem_param: RTL and testbench

Parametrised single-port synchronous memory for the lab datapath, replacing the fixed 32x8 array. Adds configurable width, depth and read latency, per-byte write strobes, a read-valid pipeline, and a self-clearing reset sequence. Access conflicts are flagged and counted. Sits behind the same read/write request style used by the testbench drivers.

---
 rtl/mem_param.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_param.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_param.sv
// -----------------------------------------------------------------------------
// mem_param
//
// Parametrised single-port synchronous memory with per-byte write strobes,
// a fixed-latency read-valid pipeline, a self-clearing sequence after reset
// and a saturating counter of rejected requests.
//
// After reset the block walks every address once and writes zero (CLEAR). It
// then serves requests (IDLE). A read samples the addressed word at the issue
// edge. The snapshot travels down an RD_LAT-deep pipeline, so a later write
// cannot disturb a read that is already in flight.
//
// Parameters
//   DATA_W     data width, a multiple of 8 in the range 8..64
//   ADDR_W     address width; depth = 2**ADDR_W words
//   RD_LAT     read latency in cycles, 1..4
//   ERR_CNT_W  width of the rejected-request counter
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   write      write request
//   read       read request
//   adder      word address
//   data_in    write data
//   be         byte enables; bit i gates data_in[8i+7:8i]
//   data_out   read data; holds the last valid value while rd_valid = 0
//   rd_valid   data_out carries a read issued RD_LAT cycles earlier
//   busy       clear sequence running; every request is rejected
//   err        one-cycle pulse following a rejected request
//   err_count  saturating count of rejected requests
// -----------------------------------------------------------------------------
module mem_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 5,
  parameter int RD_LAT    = 1,
  parameter int ERR_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write,
  input  logic                  read,
  input  logic [ADDR_W-1:0]     adder,
  input  logic [DATA_W-1:0]     data_in,
  input  logic [DATA_W/8-1:0]   be,
  output logic [DATA_W-1:0]     data_out,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  err,
  output logic [ERR_CNT_W-1:0]  err_count
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_e;

  // One pipeline stage. The word is kept whenever no valid read passes
  // through, so the last stage naturally holds the last returned value.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] word;
  } rd_stage_t;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      clr_ptr_q, clr_ptr_d;
  logic                   clr_last;
  logic                   clr_we;

  logic                   wr_acc;
  logic                   rd_acc;
  logic                   reject;

  logic [DATA_W-1:0]      mem [DEPTH];

  rd_stage_t              pipe_q [RD_LAT];
  rd_stage_t              pipe_d [RD_LAT];

  logic                   err_q, err_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  // ---------------------------------------------------------------------------
  // Request classification
  // ---------------------------------------------------------------------------
  // A read and a write in the same cycle is a conflict. While the clear
  // sequence runs, any request at all is refused.
  always_comb begin
    wr_acc = (state_q == S_IDLE) && write && !read;
    rd_acc = (state_q == S_IDLE) && read && !write;
    reject = (read || write) && ((state_q == S_CLEAR) || (read && write));
  end

  // ---------------------------------------------------------------------------
  // Control FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments, so every flop in the
  // design samples pre-edge values and evaluation order never matters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next state
  // ---------------------------------------------------------------------------
  assign clr_last = &clr_ptr_q;

  // NOTE: every signal written in a combinational block gets a default first.
  // Without the default, a path that skips the assignment would infer a latch.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      S_CLEAR: begin
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_last) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_CLEAR;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy   = (state_q == S_CLEAR);
    clr_we = (state_q == S_CLEAR);
  end

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset branch. Putting it under the asynchronous
  // reset would turn the RAM into flops. The clear sequence zeroes it instead.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_ptr_q] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem[adder][8*i +: 8] <= data_in[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline
  // ---------------------------------------------------------------------------
  // Stage 0 samples the array at the issue edge. Later stages only shift, so
  // a write landing after issue never reaches an in-flight read.
  always_comb begin
    pipe_d = pipe_q;
    pipe_d[0].valid = rd_acc;
    if (rd_acc) begin
      pipe_d[0].word = mem[adder];
    end
    for (int k = 1; k < RD_LAT; k++) begin
      pipe_d[k].valid = pipe_q[k-1].valid;
      if (pipe_q[k-1].valid) begin
        pipe_d[k].word = pipe_q[k-1].word;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < RD_LAT; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < RD_LAT; k++) begin
        pipe_q[k] <= pipe_d[k];
      end
    end
  end

  assign data_out = pipe_q[RD_LAT-1].word;
  assign rd_valid = pipe_q[RD_LAT-1].valid;

  // ---------------------------------------------------------------------------
  // Rejection flag and saturating counter
  // ---------------------------------------------------------------------------
  // err follows reject by one cycle. It therefore stays high across a run of
  // back-to-back rejected requests.
  always_comb begin
    err_d     = reject;
    err_cnt_d = err_cnt_q;
    if (reject && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err       = err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_mem_param.sv
// -----------------------------------------------------------------------------
// tb_mem_param
//
// Drives two instances of mem_param from the same request stream:
//   dut_a: DATA_W=32, ADDR_W=5, RD_LAT=3, ERR_CNT_W=2
//   dut_b: DATA_W=8,  ADDR_W=5, RD_LAT=1, ERR_CNT_W=8 (fed byte 0 only)
// dut_b always holds byte 0 of dut_a's contents, so each expected read value
// serves both instances: the full word for dut_a and its low byte for dut_b.
// Every issued read pushes {expected data, due cycle} into a queue per
// instance. A monitor on the falling edge compares rd_valid against the
// queue head's due cycle, and data_out when a read is due.
// -----------------------------------------------------------------------------
module tb_mem_param;

  localparam int LAT_A = 3;
  localparam int LAT_B = 1;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        read;
  logic        write;
  logic [4:0]  adder;
  logic [31:0] data_in;
  logic [3:0]  be;

  logic [31:0] data_out_a;
  logic        rd_valid_a, busy_a, err_a;
  logic [1:0]  err_count_a;

  logic [7:0]  data_out_b;
  logic        rd_valid_b, busy_b, err_b;
  logic [7:0]  err_count_b;

  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;
  exp_t qa[$];
  exp_t qb[$];

  mem_param #(.DATA_W(32), .ADDR_W(5), .RD_LAT(LAT_A), .ERR_CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .write(write), .read(read), .adder(adder),
    .data_in(data_in), .be(be), .data_out(data_out_a), .rd_valid(rd_valid_a),
    .busy(busy_a), .err(err_a), .err_count(err_count_a)
  );

  mem_param #(.DATA_W(8), .ADDR_W(5), .RD_LAT(LAT_B), .ERR_CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .write(write), .read(read), .adder(adder),
    .data_in(data_in[7:0]), .be(be[0]), .data_out(data_out_b),
    .rd_valid(rd_valid_b), .busy(busy_b), .err(err_b), .err_count(err_count_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    logic exp_v;
    exp_v = (qa.size() > 0) && (qa[0].due == cycle);
    check("rd_valid_a", {63'd0, rd_valid_a}, {63'd0, exp_v});
    if (exp_v) begin
      check("data_out_a", {32'd0, data_out_a}, {32'd0, qa[0].data});
      void'(qa.pop_front());
    end
  end

  always @(negedge clk) begin
    logic exp_v;
    exp_v = (qb.size() > 0) && (qb[0].due == cycle);
    check("rd_valid_b", {63'd0, rd_valid_b}, {63'd0, exp_v});
    if (exp_v) begin
      check("data_out_b", {56'd0, data_out_b}, {32'd0, qb[0].data});
      void'(qb.pop_front());
    end
  end

  // Stimulus helpers: inputs change 1 time unit after a rising edge, and the
  // following edge samples them.
  task automatic drive(input logic rd, input logic wr, input logic [4:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    read    = rd;
    write   = wr;
    adder   = a;
    data_in = d;
    be      = b;
    @(posedge clk);
    #1;
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
    drive(1'b0, 1'b1, a, d, b);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e);
    qa.push_back('{data: e, due: cycle + LAT_A});
    qb.push_back('{data: {24'd0, e[7:0]}, due: cycle + LAT_B});
    drive(1'b1, 1'b0, a, 32'd0, 4'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_out_a"},  {32'd0, data_out_a}, 64'd0);
    check({tag, "_rd_valid_a"},  {63'd0, rd_valid_a}, 64'd0);
    check({tag, "_busy_a"},      {63'd0, busy_a}, 64'd1);
    check({tag, "_err_a"},       {63'd0, err_a}, 64'd0);
    check({tag, "_err_count_a"}, {62'd0, err_count_a}, 64'd0);
    check({tag, "_data_out_b"},  {56'd0, data_out_b}, 64'd0);
    check({tag, "_rd_valid_b"},  {63'd0, rd_valid_b}, 64'd0);
    check({tag, "_err_count_b"}, {56'd0, err_count_b}, 64'd0);
  endtask

  // Asserts reset mid-cycle, away from both clock edges, and drops in-flight
  // expectations because the pipeline is flushed.
  task automatic assert_reset(input string tag);
    #2;
    rst = 1'b1;
    qa.delete();
    qb.delete();
    #1;
    check_reset_outputs(tag);
  endtask

  // Called right after reset release on a falling edge; counts rising edges
  // until busy drops. The bound turns a stuck busy into a failed comparison.
  task automatic wait_clear();
    int na = 0;
    int nb = 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (!busy_a && na == 0) na = n;
      if (!busy_b && nb == 0) nb = n;
      if (na != 0 && nb != 0) break;
    end
    check("clear_len_a", 64'(na), 64'd32);
    check("clear_len_b", 64'(nb), 64'd32);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; read = 1'b0; write = 1'b0;
    adder = '0; data_in = '0; be = '0;

    // Power-on reset and clear sequence
    #1 rst = 1'b1;
    #1 check_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_clear();

    // Every address reads back zero, one read per cycle
    for (int a = 0; a < 32; a++) rd(5'(a), 32'h0);

    // Byte enables
    wr(5'd3, 32'hAABBCCDD, 4'b1111);
    wr(5'd3, 32'h11223344, 4'b0101);
    rd(5'd3, 32'hAA22CC44);

    // Back-to-back reads through the latency pipeline
    wr(5'd0, 32'h01010101, 4'hF);
    wr(5'd1, 32'h02020202, 4'hF);
    wr(5'd2, 32'h03030303, 4'hF);
    rd(5'd0, 32'h01010101);
    rd(5'd1, 32'h02020202);
    rd(5'd2, 32'h03030303);
    rd(5'd3, 32'hAA22CC44);

    // A write right after an in-flight read leaves that read's data intact.
    // A read on the next edge sees the new word.
    rd(5'd0, 32'h01010101);
    rd(5'd1, 32'h02020202);
    wr(5'd1, 32'hDEADBEEF, 4'hF);
    rd(5'd1, 32'hDEADBEEF);
    rd(5'd2, 32'h03030303);
    rd(5'd3, 32'hAA22CC44);

    // data_out holds the last returned word once the pipeline drains
    idle(6);
    check("hold_data_a",  {32'd0, data_out_a}, 64'hAA22CC44);
    check("hold_valid_a", {63'd0, rd_valid_a}, 64'd0);
    check("hold_data_b",  {56'd0, data_out_b}, 64'h44);

    // Single read/write conflict
    wr(5'd5, 32'h5A5A5A5A, 4'hF);
    drive(1'b1, 1'b1, 5'd5, 32'h00000000, 4'hF);
    check("conf_err_a",   {63'd0, err_a}, 64'd1);
    check("conf_cnt_a",   {62'd0, err_count_a}, 64'd1);
    check("conf_err_b",   {63'd0, err_b}, 64'd1);
    check("conf_cnt_b",   {56'd0, err_count_b}, 64'd1);
    idle(1);
    check("conf_err_drop_a", {63'd0, err_a}, 64'd0);
    check("conf_cnt_hold_a", {62'd0, err_count_a}, 64'd1);
    rd(5'd5, 32'h5A5A5A5A);
    idle(4);

    // Four more conflicts back to back: the 2-bit counter saturates and err
    // stays high through the run
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 5'd5, 32'hFFFFFFFF, 4'hF);
      check("sat_err_a", {63'd0, err_a}, 64'd1);
    end
    check("sat_cnt_a", {62'd0, err_count_a}, 64'd3);
    check("sat_cnt_b", {56'd0, err_count_b}, 64'd5);
    idle(1);
    check("sat_err_drop_a", {63'd0, err_a}, 64'd0);
    rd(5'd5, 32'h5A5A5A5A);
    idle(4);

    // Reset while a read is in flight
    wr(5'd7, 32'h77777777, 4'hF);
    rd(5'd7, 32'h77777777);
    check("inflight_b_data",  {56'd0, data_out_b}, 64'h77);
    check("inflight_a_valid", {63'd0, rd_valid_a}, 64'd0);
    check("inflight_a_hold",  {32'd0, data_out_a}, 64'h5A5A5A5A);
    assert_reset("inflight");
    @(negedge clk);
    rst = 1'b0;

    // A request during busy, then reset at clear cycle 10
    idle(4);
    drive(1'b1, 1'b0, 5'd0, 32'd0, 4'd0);
    check("busy_err_a", {63'd0, err_a}, 64'd1);
    check("busy_cnt_a", {62'd0, err_count_a}, 64'd1);
    check("busy_cnt_b", {56'd0, err_count_b}, 64'd1);
    idle(5);
    check("midclear_busy_a", {63'd0, busy_a}, 64'd1);
    assert_reset("midclear");
    @(negedge clk);
    rst = 1'b0;
    wait_clear();

    // Cleared again after the restarted sequence
    rd(5'd7, 32'h0);
    rd(5'd0, 32'h0);
    rd(5'd1, 32'h0);
    idle(6);
    check("queue_a_empty", 64'(qa.size()), 64'd0);
    check("queue_b_empty", 64'(qb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
